// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, levels and bus payloads.
package mem_lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  typedef struct packed {
    logic [REG_W-1:0]  wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } wb_bus_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: decodes access size, builds byte selects, replicates
// store data, extracts/extends load data and flags misaligned accesses (big-endian).
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]        aluop,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              is_load,
  output logic              is_store,
  output logic              is_ll,
  output logic              is_sc,
  output logic [3:0]        sel,
  output logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              adel,
  output logic              ades
);

  acc_size_e size;
  logic      sext;
  logic      misaligned;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size     = SZ_NONE;
    sext     = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    unique case (aluop)
      OP_LB:        begin size = SZ_BYTE; is_load = 1'b1; sext = 1'b1; end
      OP_LBU:       begin size = SZ_BYTE; is_load = 1'b1; end
      OP_LH:        begin size = SZ_HALF; is_load = 1'b1; sext = 1'b1; end
      OP_LHU:       begin size = SZ_HALF; is_load = 1'b1; end
      OP_LW, OP_LL: begin size = SZ_WORD; is_load = 1'b1; end
      OP_SB:        begin size = SZ_BYTE; is_store = 1'b1; end
      OP_SH:        begin size = SZ_HALF; is_store = 1'b1; end
      OP_SW, OP_SC: begin size = SZ_WORD; is_store = 1'b1; end
      default:      ;
    endcase
  end

  assign is_ll      = (aluop == OP_LL);
  assign is_sc      = (aluop == OP_SC);
  assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));
  assign adel       = is_load  & misaligned;
  assign ades       = is_store & misaligned;

  // Lane 3 (bits 31:24) holds the lowest byte address.
  always_comb begin
    byte_v = ram_rdata[31:24];
    unique case (addr_lo)
      2'b00: byte_v = ram_rdata[31:24];
      2'b01: byte_v = ram_rdata[23:16];
      2'b10: byte_v = ram_rdata[15:8];
      2'b11: byte_v = ram_rdata[7:0];
      default: ;
    endcase
    half_v = addr_lo[1] ? ram_rdata[15:0] : ram_rdata[31:16];
  end

  always_comb begin
    sel     = 4'b0000;
    st_data = store_data;
    ld_data = ram_rdata;
    unique case (size)
      SZ_BYTE: begin
        sel     = 4'b1000 >> addr_lo;
        st_data = {4{store_data[7:0]}};
        ld_data = sext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      SZ_HALF: begin
        sel     = addr_lo[1] ? 4'b0011 : 4'b1100;
        st_data = {2{store_data[15:0]}};
        ld_data = sext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      SZ_WORD: sel = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MIPS MEM stage: drives the data RAM, resolves LL/SC via a link bit and owns the
// MEM/WB pipeline register with flush/stall handling.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter bit          LL_CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stall,
  input  logic              flush,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic              excp_adel_o,
  output logic              excp_ades_o,
  output logic [ADDR_W-1:0] bad_vaddr_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [31:0]       wb_wdata_o
);

  logic              is_load, is_store, is_ll, is_sc;
  logic [3:0]        sel;
  logic [DATA_W-1:0] st_data, ld_data;
  logic              adel, ades;
  logic              misaligned, sc_fail, mem_go;
  logic              link_q;
  wb_bus_t           wb_d, wb_q;

  lsu_align u_align (
    .aluop      (aluop_i),
    .addr_lo    (mem_addr_i[1:0]),
    .store_data (store_data_i),
    .ram_rdata  (ram_data_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_ll      (is_ll),
    .is_sc      (is_sc),
    .sel        (sel),
    .st_data    (st_data),
    .ld_data    (ld_data),
    .adel       (adel),
    .ades       (ades)
  );

  assign misaligned = adel | ades;
  assign sc_fail    = is_sc & ~link_q;
  assign mem_go     = (is_load | is_store) & ~misaligned & ~sc_fail;

  // RAM side; a stalled store keeps the access but withholds the write strobe.
  always_comb begin
    ram_ce_o    = mem_go ? CHIP_ENABLE : CHIP_DISABLE;
    ram_we_o    = (mem_go & is_store & ~stall[0]) ? WRITE_ENABLE : WRITE_DISABLE;
    ram_addr_o  = mem_go ? mem_addr_i : '0;
    ram_sel_o   = mem_go ? sel : 4'b0000;
    ram_data_o  = mem_go ? st_data : ZERO_WORD;
    excp_adel_o = adel;
    excp_ades_o = ades;
    bad_vaddr_o = misaligned ? mem_addr_i : '0;
  end

  always_comb begin
    wb_d.wd    = wd_i;
    wb_d.wreg  = wreg_i & ~misaligned;
    wb_d.wdata = wdata_i;
    if (is_load)    wb_d.wdata = ld_data;
    else if (is_sc) wb_d.wdata = DATA_W'(link_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (stall[0] && !stall[1]) begin
      wb_q <= '0;
    end else if (!stall[1]) begin
      wb_q <= wb_d;
    end
  end

  // Any SC consumes the reservation; a misaligned LL never establishes one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_q <= 1'b0;
    end else if (flush) begin
      if (LL_CLR_ON_FLUSH) link_q <= 1'b0;
    end else if (!stall[0]) begin
      if (is_ll && !misaligned) link_q <= 1'b1;
      else if (is_sc)           link_q <= 1'b0;
    end
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-addressed reference memory and link model,
// directed scenarios followed by randomized traffic.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic        flush;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, store_data_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i, bad_vaddr_o;
  logic [3:0]  ram_sel_o;
  logic        excp_adel_o, excp_ades_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .LL_CLR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o), .bad_vaddr_o(bad_vaddr_o),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o)
  );

  // Word-organised RAM attached to the DUT (environment, not the reference).
  logic [31:0] ram [64];
  logic        init_en;
  logic [5:0]  init_idx;
  logic [31:0] init_val;
  assign ram_data_i = ram[ram_addr_o[7:2]];

  always @(posedge clk) begin
    if (init_en) ram[init_idx] <= init_val;
    else if (ram_ce_o && ram_we_o)
      for (int l = 0; l < 4; l++)
        if (ram_sel_o[l]) ram[ram_addr_o[7:2]][8*l +: 8] <= ram_data_o[8*l +: 8];
  end

  // Reference model state.
  logic [7:0]  ref_mem [256];
  bit          link_m;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  bit          m_chk;

  typedef struct {
    bit ce, we, adel, ades, sto;
    logic [3:0]  sel;
    logic [31:0] addr, data;
    logic [4:0]  wd;
    bit          wreg, chk;
    logic [31:0] wdata;
  } rec_t;

  rec_t q[$];
  int tests = 0;
  int fails = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  // Monitor: combinational RAM/exception outputs for the current record, then
  // the registered MEM/WB outputs one cycle later.
  rec_t pend;
  bit   pend_v = 1'b0;
  always @(negedge clk) begin
    rec_t r;
    if (pend_v) begin
      chk("wb_wd", 32'(wb_wd_o), 32'(pend.wd));
      chk("wb_wreg", 32'(wb_wreg_o), 32'(pend.wreg));
      if (pend.chk) chk("wb_wdata", wb_wdata_o, pend.wdata);
    end
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("ram_ce", 32'(ram_ce_o), 32'(r.ce));
      chk("ram_we", 32'(ram_we_o), 32'(r.we));
      chk("excp_adel", 32'(excp_adel_o), 32'(r.adel));
      chk("excp_ades", 32'(excp_ades_o), 32'(r.ades));
      if (r.adel || r.ades) chk("bad_vaddr", bad_vaddr_o, r.addr);
      if (r.ce) begin
        chk("ram_addr", ram_addr_o, r.addr);
        chk("ram_sel", 32'(ram_sel_o), 32'(r.sel));
        if (r.sto) chk("ram_data", ram_data_o, r.data);
      end
      pend   = r;
      pend_v = 1'b1;
    end else begin
      pend_v = 1'b0;
    end
  end

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [1:0] st, input logic fl);
    rec_t r;
    int size, off;
    bit ld, sto, sgn, mis;
    longint v;
    logic [31:0] res;
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = a; store_data_i = sd; stall = st; flush = fl;
    wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
    size = 0; ld = 0; sto = 0; sgn = 0;
    case (op)
      OP_LB:        begin size = 1; ld = 1; sgn = 1; end
      OP_LBU:       begin size = 1; ld = 1; end
      OP_LH:        begin size = 2; ld = 1; sgn = 1; end
      OP_LHU:       begin size = 2; ld = 1; end
      OP_LW, OP_LL: begin size = 4; ld = 1; end
      OP_SB:        begin size = 1; sto = 1; end
      OP_SH:        begin size = 2; sto = 1; end
      OP_SW, OP_SC: begin size = 4; sto = 1; end
      default: ;
    endcase
    off    = int'(a % 4);
    mis    = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
    r.adel = ld && mis;
    r.ades = sto && mis;
    r.sto  = sto;
    r.ce   = (ld || sto) && !mis && !(op == OP_SC && !link_m);
    r.we   = r.ce && sto && !st[0];
    r.sel  = (size == 1) ? 4'(1 << (3 - off)) : (size == 2) ? 4'(3 << (2 - off)) : 4'hF;
    r.data = (size == 1) ? 32'(sd[7:0]) * 32'h01010101 :
             (size == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;
    r.addr = a;
    if (ld) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v * 256 + longint'(ref_mem[(int'(a) + i) % 256]);
      if (sgn && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
      res = 32'(v);
    end else if (op == OP_SC) begin
      res = link_m ? 32'd1 : 32'd0;
    end else begin
      res = wdata_i;
    end
    if (r.we)
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = 8'(sd >> (8 * (size - 1 - i)));
    if (fl || (st[0] && !st[1])) begin
      m_wd = 0; m_wreg = 0; m_wdata = 0; m_chk = 1;
    end else if (!st[1]) begin
      m_wd = wd_i; m_wreg = wreg_i && !mis; m_wdata = res; m_chk = !(ld && mis);
    end
    if (fl) link_m = 0;
    else if (!st[0]) begin
      if (op == OP_LL && !mis) link_m = 1;
      else if (op == OP_SC)    link_m = 0;
    end
    r.wd = m_wd; r.wreg = m_wreg; r.wdata = m_wdata; r.chk = m_chk;
    q.push_back(r);
  endtask

  task automatic nop(input logic [1:0] st, input logic fl);
    issue(8'h21, 32'h0, 32'h0, st, fl);
  endtask

  task automatic settle();
    nop(2'b00, 1'b0);
    @(negedge clk); @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ops [11];
  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    int          s;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_LL, OP_SC, 8'h21};
    rst = 1'b0; stall = 2'b00; flush = 1'b0; aluop_i = 8'h00; mem_addr_i = 0;
    store_data_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
    link_m = 0; m_wd = 0; m_wreg = 0; m_wdata = 0; m_chk = 1;
    init_en = 1'b1; init_idx = 0; init_val = 0;
    for (int w = 0; w < 64; w++) begin
      init_idx = 6'(w); init_val = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = 8'(init_val >> (24 - 8*b));
      @(posedge clk); #1;
    end
    init_en = 1'b0;

    chk("reset_wb_wd", 32'(wb_wd_o), 32'h0);
    chk("reset_wb_wreg", 32'(wb_wreg_o), 32'h0);
    chk("reset_wb_wdata", wb_wdata_o, 32'h0);
    chk("reset_ram_ce", 32'(ram_ce_o), 32'h0);
    chk("reset_ram_we", 32'(ram_we_o), 32'h0);
    chk("reset_excp", 32'({excp_adel_o, excp_ades_o}), 32'h0);
    rst = 1'b1;

    issue(OP_SW, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
    issue(OP_LB, 32'h11, 32'h0, 2'b00, 1'b0);
    issue(OP_SH, 32'h22, 32'h00001234, 2'b00, 1'b0);
    issue(OP_LHU, 32'h22, 32'h0, 2'b00, 1'b0);
    issue(OP_LW, 32'h06, 32'h0, 2'b00, 1'b0);
    issue(OP_SH, 32'h03, 32'h5555, 2'b00, 1'b0);
    issue(OP_LL, 32'h40, 32'h0, 2'b00, 1'b0);
    issue(OP_SC, 32'h40, 32'd7, 2'b00, 1'b0);
    issue(OP_SC, 32'h40, 32'd9, 2'b00, 1'b0);
    issue(OP_LW, 32'h40, 32'h0, 2'b00, 1'b0);
    issue(OP_LL, 32'h40, 32'h0, 2'b00, 1'b0);
    nop(2'b00, 1'b1);
    issue(OP_SC, 32'h40, 32'd5, 2'b00, 1'b0);
    issue(OP_LL, 32'h44, 32'h0, 2'b00, 1'b1);
    issue(OP_SC, 32'h44, 32'd6, 2'b00, 1'b0);
    issue(OP_LW, 32'h40, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) issue(OP_SW, 32'h50, 32'hCAFEF00D, 2'b01, 1'b0);
    issue(OP_SW, 32'h50, 32'hCAFEF00D, 2'b00, 1'b0);
    issue(OP_LW, 32'h50, 32'h0, 2'b00, 1'b0);
    issue(OP_SB, 32'h57, 32'h000000A5, 2'b11, 1'b0);
    issue(OP_SB, 32'h57, 32'h000000A5, 2'b11, 1'b0);
    issue(OP_LBU, 32'h57, 32'h0, 2'b00, 1'b0);

    // Async reset with a live reservation and a non-zero MEM/WB register.
    issue(OP_LL, 32'h80, 32'h0, 2'b00, 1'b0);
    settle();
    rst = 1'b0;
    #1;
    chk("midreset_wb_wdata", wb_wdata_o, 32'h0);
    chk("midreset_wb_wd", 32'(wb_wd_o), 32'h0);
    link_m = 0; m_wd = 0; m_wreg = 0; m_wdata = 0; m_chk = 1;
    #1 rst = 1'b1;
    nop(2'b00, 1'b0);
    issue(OP_SC, 32'h80, 32'h12345678, 2'b00, 1'b0);
    issue(OP_LW, 32'h80, 32'h0, 2'b00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 10)];
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) begin
        if (op == OP_LH || op == OP_LHU || op == OP_SH) a[0] = 1'b0;
        if (op == OP_LW || op == OP_LL || op == OP_SW || op == OP_SC) a[1:0] = 2'b00;
      end
      s = $urandom_range(0, 9);
      issue(op, a, $urandom,
            (s < 6) ? 2'b00 : (s < 8) ? 2'b01 : (s < 9) ? 2'b11 : 2'b10,
            ($urandom_range(0, 19) == 0));
    end
    settle();
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
